// File: rtl/hasher_axi_lite_slave.sv
// hasher_axi_lite_slave
// AXI4-Lite responder holding the four 32-bit software-visible registers of
// the hasher IP at byte offsets 0x0, 0x4, 0x8 and 0xC.
// Ports:
//   ACLK, ARESET          : clock and synchronous active-high reset
//   S_AXI_AW* / S_AXI_W*  : write address / write data channels
//   S_AXI_B*              : write response channel (always OKAY)
//   S_AXI_AR* / S_AXI_R*  : read address / read data channels (always OKAY)
//   regs_out              : {reg3, reg2, reg1, reg0} to the hasher core
//   reg_wr_pulse          : one-cycle pulse, bit i set when reg i is committed
module hasher_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   regs_out,
  output logic [3:0]                        reg_wr_pulse
);

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wstate_t;

  // Byte-lane merge: lanes with a cleared strobe keep their old contents.
  function automatic logic [31:0] f_merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
    logic [31:0] m;
    m = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        m[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        m[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return m;
  endfunction

  wstate_t      r_wstate;
  logic         r_awready;
  logic         r_wready;
  logic         r_bvalid;
  logic [1:0]   r_awidx;
  logic [31:0]  r_wdata;
  logic [3:0]   r_wstrb;
  logic [31:0]  r_regs [4];
  logic [3:0]   r_wr_pulse;
  logic         r_arready;
  logic         r_rvalid;
  logic [31:0]  r_rdata;

  logic         w_aw_hs;
  logic         w_w_hs;
  logic         w_ar_hs;
  logic         w_commit;
  logic [1:0]   w_cidx;
  logic [31:0]  w_cdata;
  logic [3:0]   w_cstrb;
  logic         w_unused;

  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs  = S_AXI_WVALID & r_wready;
  assign w_ar_hs = S_AXI_ARVALID & r_arready;

  // Protection bits and byte-offset address bits carry no meaning here.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Commit decode: pick address/data from the live bus or the latched copy,
  // depending on which channel completes the pair this cycle.
  always_comb begin
    w_commit = 1'b0;
    w_cidx   = r_awidx;
    w_cdata  = r_wdata;
    w_cstrb  = r_wstrb;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit = 1'b1;
          w_cidx   = S_AXI_AWADDR[3:2];
          w_cdata  = S_AXI_WDATA;
          w_cstrb  = S_AXI_WSTRB;
        end else begin
          w_commit = 1'b0;
        end
      end
      W_HAVE_ADDR: begin
        if (w_w_hs) begin
          w_commit = 1'b1;
          w_cdata  = S_AXI_WDATA;
          w_cstrb  = S_AXI_WSTRB;
        end else begin
          w_commit = 1'b0;
        end
      end
      W_HAVE_DATA: begin
        if (w_aw_hs) begin
          w_commit = 1'b1;
          w_cidx   = S_AXI_AWADDR[3:2];
        end else begin
          w_commit = 1'b0;
        end
      end
      default: begin
        w_commit = 1'b0;
      end
    endcase
  end

  // Write FSM with registered AWREADY/WREADY/BVALID; one write outstanding.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_awidx   <= 2'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
          end else if (w_aw_hs) begin
            r_awidx   <= S_AXI_AWADDR[3:2];
            r_wstate  <= W_HAVE_ADDR;
            r_awready <= 1'b0;
          end else if (w_w_hs) begin
            r_wdata   <= S_AXI_WDATA;
            r_wstrb   <= S_AXI_WSTRB;
            r_wstate  <= W_HAVE_DATA;
            r_wready  <= 1'b0;
          end
        end
        W_HAVE_ADDR: begin
          if (w_commit) begin
            r_wstate <= W_RESP;
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
          end
        end
        W_HAVE_DATA: begin
          if (w_commit) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Register file update and the per-register commit pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= 32'd0;
      end
      r_wr_pulse <= 4'd0;
    end else begin
      r_wr_pulse <= 4'd0;
      if (w_commit) begin
        r_regs[w_cidx] <= f_merge_bytes(r_regs[w_cidx], w_cdata, w_cstrb);
        r_wr_pulse     <= 4'b0001 << w_cidx;
      end
    end
  end

  // Read channel: RDATA samples the register before any same-edge commit.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      if (w_ar_hs) begin
        r_rdata   <= r_regs[S_AXI_ARADDR[3:2]];
        r_rvalid  <= 1'b1;
        r_arready <= 1'b0;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign regs_out      = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
  assign reg_wr_pulse  = r_wr_pulse;

endmodule

// File: tb/tb_hasher_axi_lite_slave.sv
module tb_hasher_axi_lite_slave;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [3:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [3:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] regs_out;
  logic [3:0]   reg_wr_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side register model and scoreboards.
  logic [31:0] m_regs [4];
  logic [31:0] rd_q [$];
  logic [3:0]  pulse_q [$];

  hasher_axi_lite_slave dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .regs_out      (regs_out),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 ACLK = ~ACLK;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    end
    return r;
  endfunction

  // Every task starts and ends on a falling edge.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, input bit b_early);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_fire = 1'b0;
    bit w_fire  = 1'b0;
    bit early_b = 1'b0;
    int cyc = 0;
    logic [1:0] idx;
    logic [3:0] one;
    idx = addr[3:2];
    one = 4'b0001;
    pulse_q.push_back(one << idx);
    S_AXI_BREADY = b_early;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (cyc > 0) @(negedge ACLK);
      if (aw_fire) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
      if (!(aw_done && w_done)) begin
        if (S_AXI_BVALID) early_b = 1'b1;
        if (!aw_done && cyc >= aw_dly) S_AXI_AWVALID = 1'b1;
        if (!w_done && cyc >= w_dly)   S_AXI_WVALID  = 1'b1;
        aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
        w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      end
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check_val("wr_handshake_done", {aw_done, w_done}, 2'b11);
    check_val("wr_no_early_bvalid", early_b, 1'b0);
    m_regs[idx] = model_merge(m_regs[idx], data, strb);
    // One cycle after the completing handshake.
    check_val("wr_bvalid", S_AXI_BVALID, 1'b1);
    check_val("wr_bresp", S_AXI_BRESP, 2'b00);
    if (S_AXI_BVALID) begin
      check_val("wr_pulse", reg_wr_pulse, pulse_q.pop_front());
    end
    check_val("wr_regs_out", regs_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    for (int i = 0; i < b_dly; i++) begin
      @(negedge ACLK);
      check_val("wr_bvalid_hold", S_AXI_BVALID, 1'b1);
      check_val("wr_ready_low", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check_val("wr_bvalid_drop", S_AXI_BVALID, 1'b0);
    check_val("wr_ready_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    check_val("wr_pulse_clear", reg_wr_pulse, 4'b0000);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] addr, input int r_dly);
    bit fired = 1'b0;
    int cyc = 0;
    logic [31:0] first;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    rd_q.push_back(m_regs[addr[3:2]]);
    while (cyc < 20) begin
      if (S_AXI_ARREADY) fired = 1'b1;
      @(negedge ACLK);
      cyc++;
      if (fired) break;
    end
    S_AXI_ARVALID = 1'b0;
    check_val("rd_ar_handshake", fired, 1'b1);
    check_val("rd_rvalid", S_AXI_RVALID, 1'b1);
    check_val("rd_arready_low", S_AXI_ARREADY, 1'b0);
    first = S_AXI_RDATA;
    for (int i = 0; i < r_dly; i++) begin
      @(negedge ACLK);
      check_val("rd_rvalid_hold", S_AXI_RVALID, 1'b1);
      check_val("rd_rdata_stable", S_AXI_RDATA, first);
      check_val("rd_arready_hold", S_AXI_ARREADY, 1'b0);
    end
    S_AXI_RREADY = 1'b1;
    if (S_AXI_RVALID) begin
      check_val("rd_data", S_AXI_RDATA, rd_q.pop_front());
      check_val("rd_rresp", S_AXI_RRESP, 2'b00);
    end
    @(negedge ACLK);
    check_val("rd_rvalid_drop", S_AXI_RVALID, 1'b0);
    check_val("rd_arready_back", S_AXI_ARREADY, 1'b1);
    S_AXI_RREADY = 1'b0;
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESET        = 1'b1;
    S_AXI_AWADDR  = 4'h0;
    S_AXI_AWPROT  = 3'b000;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = 32'h0;
    S_AXI_WSTRB   = 4'h0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = 4'h0;
    S_AXI_ARPROT  = 3'b000;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_val("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    check_val("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    check_val("rst_rdata", S_AXI_RDATA, 32'h0);
    check_val("rst_regs", regs_out, 128'h0);
    check_val("rst_pulse", reg_wr_pulse, 4'b0000);
    ARESET = 1'b0;
    @(negedge ACLK);

    // 1: full-word writes to each register, read back after each
    do_write(4'h0, 32'h0101FFFF, 4'hF, 0, 0, 0, 1'b0); do_read(4'h0, 0);
    do_write(4'h4, 32'hABCD0001, 4'hF, 0, 0, 0, 1'b0); do_read(4'h4, 0);
    do_write(4'h8, 32'hDEAD0011, 4'hF, 0, 0, 0, 1'b0); do_read(4'h8, 0);
    do_write(4'hC, 32'hBEEF0011, 4'hF, 0, 0, 0, 1'b0); do_read(4'hC, 0);
    check_val("t1_regs_out", regs_out, {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF});

    // 2: W three cycles ahead of AW, then AW three cycles ahead of W; BREADY early
    do_write(4'hD, 32'h55AA33CC, 4'hF, 3, 0, 0, 1'b1);
    repeat (3) begin
      @(negedge ACLK);
      check_val("t2_no_second_b", S_AXI_BVALID, 1'b0);
    end
    do_write(4'h1, 32'h0F0F1234, 4'hF, 0, 3, 0, 1'b0);
    repeat (3) begin
      @(negedge ACLK);
      check_val("t2_no_second_b", S_AXI_BVALID, 1'b0);
    end
    do_read(4'hE, 0);
    do_read(4'h3, 0);

    // 3: partial strobe write
    do_write(4'h4, 32'h11223344, 4'h5, 0, 0, 0, 1'b0);
    check_val("t3_reg1", regs_out[63:32], 32'hAB220044);
    do_read(4'h4, 0);

    // 4: stalled response channels
    do_write(4'h0, 32'hCAFEF00D, 4'hF, 1, 1, 5, 1'b0);
    do_read(4'h0, 5);

    // 5: read and commit to the same register on the same edge
    S_AXI_AWADDR  = 4'h8;
    S_AXI_WDATA   = 32'h12345678;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_ARADDR  = 4'h8;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    rd_q.push_back(m_regs[2]);
    pulse_q.push_back(4'b0100);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    m_regs[2] = 32'h12345678;
    check_val("t5_bvalid", S_AXI_BVALID, 1'b1);
    if (S_AXI_BVALID) check_val("t5_pulse", reg_wr_pulse, pulse_q.pop_front());
    check_val("t5_rvalid", S_AXI_RVALID, 1'b1);
    if (S_AXI_RVALID) check_val("t5_rdata_old", S_AXI_RDATA, rd_q.pop_front());
    check_val("t5_rdata_const", S_AXI_RDATA, 32'hDEAD0011);
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    check_val("t5_valids_drop", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    do_read(4'h8, 0);

    // 6: reset with AW latched (W pending) and RVALID high
    S_AXI_AWADDR  = 4'h4;
    S_AXI_AWVALID = 1'b1;
    S_AXI_ARADDR  = 4'h0;
    S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_ARVALID = 1'b0;
    check_val("t6_rvalid_pre", S_AXI_RVALID, 1'b1);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
    check_val("t6_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    check_val("t6_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    check_val("t6_regs", regs_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    check_val("t6_pulse", reg_wr_pulse, 4'b0000);
    // The dropped AW must not pair with a later W.
    S_AXI_WDATA  = 32'hFFFFFFFF;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    check_val("t6_no_commit_pulse", reg_wr_pulse, 4'b0000);
    check_val("t6_no_bvalid", S_AXI_BVALID, 1'b0);
    check_val("t6_regs_after_w", regs_out, 128'h0);

    check_val("sb_rd_empty", rd_q.size(), 0);
    check_val("sb_pulse_empty", pulse_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hasher_axi_lite_slave.md
Name: hasher_axi_lite_slave

Overview:
AXI4-Lite responder (slave) for the hasher IP. It terminates the S00_AXI interface driven by the master BFM and by the PS. It holds four 32-bit software-visible registers at byte offsets 0x0, 0x4, 0x8 and 0xC. It exports the register contents and per-register write strobes to the hasher core.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, address bits decoded; register index = addr[3:2].

Ports:
ACLK  in  1  single clock; all logic on the rising edge
ARESET  in  1  synchronous reset, active-high
S_AXI_AWADDR  in  4  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte lane enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response, always 2'b00 (OKAY)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  4  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response, always 2'b00 (OKAY)
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
regs_out  out  128  {reg3,reg2,reg1,reg0}
reg_wr_pulse  out  4  one-cycle pulse, bit i = reg i committed

Behaviour:
- Reset (ARESET=1 at a rising edge): all registers 0, AWREADY/WREADY/ARREADY=1, BVALID/RVALID=0, RDATA=0, reg_wr_pulse=0. Any in-flight transaction is dropped; nothing is committed.
- Write FSM states:
  - W_IDLE: awaiting both AW and W.
  - W_HAVE_ADDR: AW latched, W outstanding.
  - W_HAVE_DATA: W latched, AW outstanding.
  - W_RESP: BVALID=1.
- AWREADY=1 in W_IDLE and W_HAVE_DATA. WREADY=1 in W_IDLE and W_HAVE_ADDR. Both are 0 in W_RESP (one outstanding write).
- A handshake on a channel latches that channel's payload.
- Commit occurs on the edge where the second of AW/W handshakes completes. If both handshake in the same cycle, commit occurs on that edge.
  - The commit updates register addr[3:2] byte-wise per WSTRB; lanes with strobe 0 are unchanged.
  - reg_wr_pulse[idx]=1 for the following cycle.
  - State becomes W_RESP, so BVALID is asserted 1 cycle after the completing handshake.
- W_RESP -> W_IDLE on BVALID&BREADY. AWREADY/WREADY return to 1 the next cycle.
- BVALID is held until BREADY. BREADY may be high before BVALID.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake: RDATA <= reg[araddr[3:2]], RVALID=1 next cycle.
  - RVALID and RDATA are held stable until RVALID&RREADY. RVALID then drops and ARREADY rises the next cycle.
- Read and write paths are independent. Address bits [1:0] are ignored; there are no error responses.
- Simultaneous read of register X and commit to register X on the same edge: the read returns the pre-write value.
- Back-to-back reads: throughput is at most one read per 2 cycles. Back-to-back writes: at most one write per 2 cycles when BREADY is held high.

Test Plan:
1. Reset, then write 0x0101FFFF @0x0, 0xABCD0001 @0x4, 0xDEAD0011 @0x8, 0xBEEF0011 @0xC (WSTRB=0xF), reading back after each.
   -> Each read returns the written value; BRESP=RRESP=00; regs_out={BEEF0011,DEAD0011,ABCD0001,0101FFFF}; reg_wr_pulse=0001,0010,0100,1000 in order.
2. W asserted 3 cycles before AW, and separately AW 3 cycles before W.
   -> Single commit; BVALID one cycle after the later handshake; no second BVALID.
3. Reg1=0xABCD0001, then write 0x11223344 with WSTRB=0x5 to 0x4.
   -> Reg1=0xAB220044.
4. BREADY held low 5 cycles after BVALID; RREADY held low 5 cycles after RVALID.
   -> BVALID/RVALID/RDATA held stable; AWREADY/WREADY/ARREADY stay 0 throughout.
5. Same-cycle AR to 0x8 and completing AW/W to 0x8 with data 0x12345678, reg2=0xDEAD0011.
   -> RDATA=0xDEAD0011; a subsequent read returns 0x12345678.
6. ARESET asserted the cycle after AW handshake (W pending) and with RVALID high.
   -> Next cycle BVALID=RVALID=0, ready signals=1, registers 0, no reg_wr_pulse.
